// File: rtl/id_issue_fifo_if.sv
// Decode-to-issue handshake bundle: decoder side (valid/ready), issue side (valid/ack),
// flush, plus occupancy and pending-control-flow status.
interface id_issue_fifo_if #(
   parameter int DataWidth = 128,
   parameter int Depth     = 4
) ();
   localparam int CntW = $clog2(Depth) + 1;

   logic                 flush_i;
   logic [DataWidth-1:0] data_i;
   logic                 ctrl_flow_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [DataWidth-1:0] data_o;
   logic                 ctrl_flow_o;
   logic                 valid_o;
   logic                 ack_i;
   logic [CntW-1:0]      count_o;
   logic                 ctrl_flow_pending_o;

   modport master (
      output flush_i, data_i, ctrl_flow_i, valid_i, ack_i,
      input  ready_o, data_o, ctrl_flow_o, valid_o, count_o, ctrl_flow_pending_o
   );

   modport slave (
      input  flush_i, data_i, ctrl_flow_i, valid_i, ack_i,
      output ready_o, data_o, ctrl_flow_o, valid_o, count_o, ctrl_flow_pending_o
   );
endinterface

// File: rtl/id_issue_fifo.sv
// Depth-entry FIFO between decode and issue, holding decoded entries plus their
// control-flow flag, with occupancy and pending-control-flow reporting.
module id_issue_fifo #(
   parameter int DataWidth = 128,
   parameter int Depth     = 4
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   id_issue_fifo_if.slave bus
);
   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [DataWidth-1:0] data_q [Depth];
   logic [Depth-1:0]     cf_q;
   logic [PtrW-1:0]      rd_q;
   logic [PtrW-1:0]      wr_q;
   logic [CntW-1:0]      cnt_q;
   logic [CntW-1:0]      cf_cnt_q;

   logic valid;
   logic head_cf;
   logic pop;
   logic ready;
   logic push;

   assign valid   = (cnt_q != '0);
   assign head_cf = cf_q[rd_q];
   assign pop     = bus.ack_i && valid;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign ready   = (cnt_q < CntW'(Depth)) || pop;
   assign push    = bus.valid_i && ready;

   assign bus.ready_o             = ready;
   assign bus.valid_o             = valid;
   assign bus.data_o              = data_q[rd_q];
   assign bus.ctrl_flow_o         = head_cf;
   assign bus.count_o             = cnt_q;
   assign bus.ctrl_flow_pending_o = (cf_cnt_q != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) data_q[i] <= '0;
         cf_q     <= '0;
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
         cf_cnt_q <= '0;
      end else if (bus.flush_i) begin
         // Storage is left as-is; only the bookkeeping is cleared.
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
         cf_cnt_q <= '0;
      end else begin
         if (push) begin
            data_q[wr_q] <= bus.data_i;
            cf_q[wr_q]   <= bus.ctrl_flow_i;
            wr_q         <= wr_q + PtrW'(1);
         end
         if (pop) rd_q <= rd_q + PtrW'(1);
         cnt_q    <= cnt_q + CntW'(push) - CntW'(pop);
         cf_cnt_q <= cf_cnt_q + CntW'(push && bus.ctrl_flow_i) - CntW'(pop && head_cf);
      end
   end
endmodule
